// File: rtl/interfaz_memoria_datos_if.sv
// interfaz_memoria_datos_if: external SRAM-style bus between the data-memory responder and the memory
interface interfaz_memoria_datos_if;
  logic [15:0] o_Mem_Dir;
  logic [7:0]  o_Mem_Dato;
  logic [7:0]  i_Mem_Dato;
  logic        i_Mem_Listo;
  logic        o_Mem_Cs;
  logic        o_Mem_We;
  logic        o_Mem_Oe;
  modport master(output o_Mem_Dir, o_Mem_Dato, o_Mem_Cs, o_Mem_We, o_Mem_Oe, input i_Mem_Dato, i_Mem_Listo);
  modport slave(input o_Mem_Dir, o_Mem_Dato, o_Mem_Cs, o_Mem_We, o_Mem_Oe, output i_Mem_Dato, i_Mem_Listo);
endinterface

// File: rtl/interfaz_memoria_datos.sv
// interfaz_memoria_datos: wait-stated load/store responder between the register bank and an external SRAM bus
module interfaz_memoria_datos #(
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Valido,
  input  logic [8:0]  i_Instrucciones,
  input  logic [15:0] i_DireccionDato,
  input  logic [7:0]  i_Dato_Escritura,
  output logic [7:0]  o_Datos_Entrada,
  output logic        o_Listo,
  output logic        o_Error,
  output logic        o_Ocupado,
  interfaz_memoria_datos_if.master m_bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [7:0] WC_M1  = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] TO_M1  = 8'(TIMEOUT - 1);
  logic [1:0]  r_Estado;
  logic [7:0]  r_Cnt;
  logic        r_Err;
  logic        r_Wr;
  logic [15:0] r_Dir;
  logic [7:0]  r_Dato;
  logic [2:0]  w_Op;
  logic        w_Load;
  logic        w_Store;
  logic        w_Fin;
  logic        w_To;
  logic        w_unused;
  assign w_Op     = i_Instrucciones[8:6];
  assign w_unused = ^i_Instrucciones[5:0];
  assign w_Load   = w_Op == 3'b010;
  assign w_Store  = w_Op == 3'b011 || w_Op == 3'b100;
  // r_Cnt holds the number of ACCESS cycles already completed before the current one
  assign w_Fin    = r_Cnt >= WC_M1 && m_bus.i_Mem_Listo;
  assign w_To     = TIMEOUT != 0 && r_Cnt == TO_M1;
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Estado        <= IDLE;
      r_Cnt           <= '0;
      r_Err           <= 1'b0;
      r_Wr            <= 1'b0;
      r_Dir           <= '0;
      r_Dato          <= '0;
      o_Datos_Entrada <= '0;
    end else begin
      case (r_Estado)
        IDLE: if (i_Valido && (w_Load || w_Store)) begin
          r_Estado <= SETUP;
          r_Dir    <= i_DireccionDato;
          r_Wr     <= w_Store;
          r_Dato   <= w_Store ? i_Dato_Escritura : r_Dato;
          r_Cnt    <= '0;
          r_Err    <= 1'b0;
        end
        SETUP: r_Estado <= ACCESS;
        ACCESS: begin
          r_Cnt <= r_Cnt + 8'(r_Cnt != 8'hFF);
          if (w_Fin) begin
            r_Estado        <= DONE;
            o_Datos_Entrada <= r_Wr ? o_Datos_Entrada : m_bus.i_Mem_Dato;
          end else if (w_To) begin
            r_Estado        <= DONE;
            r_Err           <= 1'b1;
            o_Datos_Entrada <= r_Wr ? o_Datos_Entrada : 8'hFF;
          end
        end
        default: r_Estado <= IDLE;
      endcase
    end
  end
  assign m_bus.o_Mem_Cs   = r_Estado == SETUP || r_Estado == ACCESS;
  assign m_bus.o_Mem_We   = r_Estado == ACCESS && r_Wr;
  assign m_bus.o_Mem_Oe   = r_Estado == ACCESS && !r_Wr;
  assign m_bus.o_Mem_Dir  = r_Dir;
  assign m_bus.o_Mem_Dato = r_Dato;
  assign o_Listo          = r_Estado == DONE;
  assign o_Error          = r_Estado == DONE && r_Err;
  assign o_Ocupado        = r_Estado != IDLE;
endmodule

// File: tb/tb_interfaz_memoria_datos.sv
// tb_interfaz_memoria_datos: randomized scenario bench with a cycle-count reference model of the memory responder
module tb_interfaz_memoria_datos;
  localparam int WC = 2;
  localparam int TO = 8;
  logic        clk = 0;
  logic        rst = 1;
  logic        valido = 0;
  logic [8:0]  instr = '0;
  logic [15:0] dir = '0;
  logic [7:0]  wdat = '0;
  logic [7:0]  datos;
  logic        listo, err, ocup;
  int n_chk = 0, n_fail = 0;
  logic [7:0]  exp_datos = 0;
  int o_listo_cyc, o_err, o_cs, o_oe, o_we, o_ocup, o_first_cs, o_bad, o_extra;
  logic [7:0] o_datos;
  interfaz_memoria_datos_if bus();
  always #5 clk = ~clk;
  interfaz_memoria_datos #(.WAIT_CYCLES(WC), .TIMEOUT(TO)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Valido(valido), .i_Instrucciones(instr),
    .i_DireccionDato(dir), .i_Dato_Escritura(wdat), .o_Datos_Entrada(datos),
    .o_Listo(listo), .o_Error(err), .o_Ocupado(ocup), .m_bus(bus.master)
  );
  // Reference: ACCESS ends at index max(WC-1, low); length capped by TO with error
  function automatic int model_cyc(input int low);
    int a;
    a = (low > WC - 1 ? low : WC - 1) + 1;
    if (TO != 0 && a > TO) a = TO;
    return 2 + a;
  endfunction
  function automatic int model_err(input int low);
    return (TO != 0 && (low > WC - 1 ? low : WC - 1) + 1 > TO) ? 1 : 0;
  endfunction
  task automatic xfer(input logic [2:0] op, input logic [15:0] a, input logic [7:0] wd, input logic [7:0] rd,
                      input int low, input bit glitch, input int revalid, input int extra);
    int acc;
    acc = 0;
    o_listo_cyc = -1; o_err = -1; o_cs = 0; o_oe = 0; o_we = 0; o_ocup = 0; o_first_cs = -1; o_bad = 0; o_extra = 0;
    @(negedge clk);
    instr = {op, 6'($urandom)}; dir = a; wdat = wd; bus.i_Mem_Dato = rd; bus.i_Mem_Listo = 0; valido = 1;
    if (ocup) o_bad++;
    for (int c = 1; c <= 40 && o_listo_cyc < 0; c++) begin
      @(negedge clk);
      valido = (c == revalid);
      if (c == revalid) begin instr = {3'b010, 6'd0}; dir = ~a; end
      if (bus.o_Mem_Cs) begin o_cs++; if (o_first_cs < 0) o_first_cs = c; end
      if (bus.o_Mem_Oe) o_oe++;
      if (bus.o_Mem_We) o_we++;
      if (ocup) o_ocup++;
      if (bus.o_Mem_We && bus.o_Mem_Oe) o_bad++;
      if (!bus.o_Mem_Cs && (bus.o_Mem_We || bus.o_Mem_Oe)) o_bad++;
      if (bus.o_Mem_Cs && bus.o_Mem_Dir !== a) o_bad++;
      if (bus.o_Mem_We && bus.o_Mem_Dato !== wd) o_bad++;
      if (err && !listo) o_bad++;
      if (listo) begin o_listo_cyc = c; o_err = err; o_datos = datos; end
      if (bus.o_Mem_Oe || bus.o_Mem_We) begin
        bus.i_Mem_Listo = acc < WC - 1 ? glitch : (acc >= low);
        acc++;
      end
    end
    valido = 0;
    for (int c = 0; c < extra; c++) begin
      @(negedge clk);
      if (bus.o_Mem_Cs || listo || ocup) o_extra++;
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({datos, listo, err, ocup, bus.o_Mem_Cs, bus.o_Mem_We, bus.o_Mem_Oe, bus.o_Mem_Dir, bus.o_Mem_Dato} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got datos=%h listo=%b err=%b ocup=%b cs=%b we=%b oe=%b dir=%h dato=%h required all zero",
               datos, listo, err, ocup, bus.o_Mem_Cs, bus.o_Mem_We, bus.o_Mem_Oe, bus.o_Mem_Dir, bus.o_Mem_Dato);
    end
    rst = 0;
    exp_datos = 8'h00;
  endtask
  task automatic test_load;
    xfer(3'b010, 16'h1234, 8'h00, 8'hA5, 0, 0, 0, 4);
    exp_datos = 8'hA5;
    n_chk++; if (o_listo_cyc !== 4) begin n_fail++; $display("FAIL load_listo_cycle: got %0d required 4", o_listo_cyc); end
    n_chk++; if (o_err !== 0) begin n_fail++; $display("FAIL load_error: got %0d required 0", o_err); end
    n_chk++; if (o_first_cs !== 1 || o_oe !== 2 || o_we !== 0) begin n_fail++; $display("FAIL load_strobes: got cs_first=%0d oe=%0d we=%0d required 1 2 0", o_first_cs, o_oe, o_we); end
    n_chk++; if (o_ocup !== 4 || o_bad !== 0 || o_extra !== 0) begin n_fail++; $display("FAIL load_bus: got ocup=%0d bad=%0d extra=%0d required 4 0 0", o_ocup, o_bad, o_extra); end
    n_chk++; if (o_datos !== 8'hA5 || datos !== 8'hA5) begin n_fail++; $display("FAIL load_data: got %h/%h required a5", o_datos, datos); end
    n_chk++; if (bus.o_Mem_Dir !== 16'h1234) begin n_fail++; $display("FAIL load_dir_hold: got %h required 1234", bus.o_Mem_Dir); end
  endtask
  task automatic test_store;
    logic [2:0] ops [2];
    ops[0] = 3'b011; ops[1] = 3'b100;
    for (int i = 0; i < 2; i++) begin
      xfer(ops[i], 16'h00FF, 8'h3C, 8'($urandom), 0, 0, 0, 3);
      n_chk++; if (o_listo_cyc !== 4 || o_err !== 0) begin n_fail++; $display("FAIL store_listo op=%b: got cyc=%0d err=%0d required 4 0", ops[i], o_listo_cyc, o_err); end
      n_chk++; if (o_we !== 2 || o_oe !== 0 || o_first_cs !== 1) begin n_fail++; $display("FAIL store_strobes op=%b: got we=%0d oe=%0d cs_first=%0d required 2 0 1", ops[i], o_we, o_oe, o_first_cs); end
      n_chk++; if (datos !== exp_datos || o_bad !== 0 || o_ocup !== 4) begin n_fail++; $display("FAIL store_data op=%b: got datos=%h bad=%0d ocup=%0d required %h 0 4", ops[i], datos, o_bad, o_ocup, exp_datos); end
      n_chk++; if (bus.o_Mem_Dato !== 8'h3C) begin n_fail++; $display("FAIL store_dato_hold: got %h required 3c", bus.o_Mem_Dato); end
    end
  endtask
  task automatic test_wait_states;
    xfer(3'b010, 16'h4321, 8'h00, 8'h5A, 5, 1, 0, 2);
    exp_datos = 8'h5A;
    n_chk++; if (o_listo_cyc !== 8 || o_err !== 0 || o_oe !== 6) begin n_fail++; $display("FAIL wait_states: got cyc=%0d err=%0d oe=%0d required 8 0 6", o_listo_cyc, o_err, o_oe); end
    n_chk++; if (datos !== 8'h5A || o_bad !== 0) begin n_fail++; $display("FAIL wait_data: got %h bad=%0d required 5a 0", datos, o_bad); end
  endtask
  task automatic test_timeout;
    xfer(3'b010, 16'h0F0F, 8'h00, 8'h11, 1000, 0, 0, 2);
    exp_datos = 8'hFF;
    n_chk++; if (o_listo_cyc !== 2 + TO || o_err !== 1 || o_oe !== TO) begin n_fail++; $display("FAIL timeout_load: got cyc=%0d err=%0d oe=%0d required %0d 1 %0d", o_listo_cyc, o_err, o_oe, 2 + TO, TO); end
    n_chk++; if (datos !== 8'hFF) begin n_fail++; $display("FAIL timeout_data: got %h required ff", datos); end
    xfer(3'b011, 16'h0F10, 8'h99, 8'h22, 1000, 1, 0, 2);
    n_chk++; if (o_listo_cyc !== 2 + TO || o_err !== 1 || datos !== exp_datos) begin n_fail++; $display("FAIL timeout_store: got cyc=%0d err=%0d datos=%h required %0d 1 %h", o_listo_cyc, o_err, datos, 2 + TO, exp_datos); end
  endtask
  task automatic test_ignored;
    logic [2:0] ops [5];
    int seen;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b101; ops[3] = 3'b110; ops[4] = 3'b111;
    for (int i = 0; i < 5; i++) begin
      seen = 0;
      @(negedge clk);
      instr = {ops[i], 6'($urandom)}; dir = 16'($urandom); valido = 1;
      @(negedge clk);
      valido = 0;
      for (int c = 0; c < 5; c++) begin
        if (bus.o_Mem_Cs || listo || ocup || err) seen++;
        @(negedge clk);
      end
      n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL ignored_op %b: got %0d active cycles required 0", ops[i], seen); end
    end
    xfer(3'b010, 16'h2222, 8'h00, 8'h77, 0, 0, 2, 8);
    exp_datos = 8'h77;
    n_chk++; if (o_listo_cyc !== 4 || o_extra !== 0 || o_cs !== 3) begin n_fail++; $display("FAIL busy_valid_ignored: got cyc=%0d extra=%0d cs=%0d required 4 0 3", o_listo_cyc, o_extra, o_cs); end
  endtask
  task automatic test_reset_mid;
    int seen;
    seen = 0;
    @(negedge clk);
    instr = {3'b011, 6'd0}; dir = 16'hBEEF; wdat = 8'h77; bus.i_Mem_Listo = 0; valido = 1;
    @(negedge clk);
    valido = 0;
    @(negedge clk);
    n_chk++; if (bus.o_Mem_We !== 1'b1) begin n_fail++; $display("FAIL reset_mid_access: got we=%b required 1", bus.o_Mem_We); end
    rst = 1;
    @(negedge clk);
    n_chk++;
    if ({bus.o_Mem_Cs, bus.o_Mem_We, bus.o_Mem_Oe, ocup, listo} !== 5'b0) begin
      n_fail++; $display("FAIL reset_mid_strobes: got cs=%b we=%b oe=%b ocup=%b listo=%b required 0", bus.o_Mem_Cs, bus.o_Mem_We, bus.o_Mem_Oe, ocup, listo);
    end
    rst = 0;
    exp_datos = 8'h00;
    bus.i_Mem_Listo = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (listo || bus.o_Mem_Cs) seen++;
    end
    n_chk++; if (seen !== 0 || datos !== 8'h00) begin n_fail++; $display("FAIL reset_mid_drop: got active=%0d datos=%h required 0 00", seen, datos); end
    xfer(3'b010, 16'hCAFE, 8'h00, 8'h3E, 0, 0, 0, 0);
    exp_datos = 8'h3E;
    n_chk++; if (o_listo_cyc !== 4 || datos !== 8'h3E || o_bad !== 0) begin n_fail++; $display("FAIL reset_mid_recover: got cyc=%0d datos=%h bad=%0d required 4 3e 0", o_listo_cyc, datos, o_bad); end
  endtask
  task automatic test_back_to_back;
    xfer(3'b011, 16'h0101, 8'hC3, 8'h00, 0, 0, 0, 0);
    n_chk++; if (o_listo_cyc !== 4) begin n_fail++; $display("FAIL b2b_first: got cyc=%0d required 4", o_listo_cyc); end
    xfer(3'b010, 16'h0202, 8'h00, 8'h4D, 1, 0, 0, 0);
    exp_datos = 8'h4D;
    n_chk++; if (o_listo_cyc !== model_cyc(1) || o_first_cs !== 1 || datos !== 8'h4D) begin n_fail++; $display("FAIL b2b_second: got cyc=%0d cs_first=%0d datos=%h required %0d 1 4d", o_listo_cyc, o_first_cs, datos, model_cyc(1)); end
  endtask
  task automatic test_random;
    logic [2:0] op;
    logic [15:0] a;
    logic [7:0] wd, rd;
    int low, ec, ee;
    bit ld;
    for (int i = 0; i < 30; i++) begin
      ld = 1'($urandom);
      op = ld ? 3'b010 : ($urandom_range(0, 1) ? 3'b011 : 3'b100);
      a = 16'($urandom); wd = 8'($urandom); rd = 8'($urandom);
      low = $urandom_range(0, 11);
      ec = model_cyc(low); ee = model_err(low);
      xfer(op, a, wd, rd, low, 1'($urandom), 0, $urandom_range(0, 2));
      if (ld) exp_datos = ee ? 8'hFF : rd;
      n_chk++;
      if (o_listo_cyc !== ec || o_err !== ee || datos !== exp_datos || o_bad !== 0 || o_extra !== 0 ||
          o_oe !== (ld ? ec - 2 : 0) || o_we !== (ld ? 0 : ec - 2) || o_ocup !== ec || bus.o_Mem_Dir !== a) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b low=%0d: got cyc=%0d err=%0d datos=%h oe=%0d we=%0d ocup=%0d bad=%0d extra=%0d required cyc=%0d err=%0d datos=%h",
                 i, op, low, o_listo_cyc, o_err, datos, o_oe, o_we, o_ocup, o_bad, o_extra, ec, ee, exp_datos);
      end
    end
  endtask
  initial begin
    bus.i_Mem_Listo = 0;
    bus.i_Mem_Dato = '0;
    test_reset;
    test_load;
    test_store;
    test_wait_states;
    test_timeout;
    test_ignored;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
